// File: rtl/mpw_wb_spi_master.sv
// Wishbone-classic SPI master (mode 0, 8-bit frames) with a 16-byte register window.
// Define SPI_IRQ_EN to store CTRL.IRQ_EN and drive irq_o; otherwise irq_o is tied low.
module mpw_wb_spi_master #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    output logic        spi_csn_o,
    input  logic        spi_miso_i,
    output logic [3:0]  io_oeb_o,
    output logic        irq_o
);

    // state    | meaning
    // ST_IDLE  | no transfer; csn follows CS_HOLD
    // ST_SETUP | csn low, MOSI = bit 7, one half period before first rise
    // ST_SHIFT | 8 x {SCK high, SCK low}; sample on rise, next bit on fall
    // ST_TAIL  | final half period with SCK low, then RXDATA/DONE update
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_TAIL} state_t;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_TX   = 2'd1;
    localparam logic [1:0] REG_RX   = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    logic [1:0] rst_sync_q;
    logic       rst_n;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rxsh_q, rxsh_d;
    logic [7:0]  rx_q, rx_d;
    logic        sck_q, sck_d;
    logic        csn_q, csn_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;

    logic       hit, bus_acc, bus_wr, bus_rd;
    logic [1:0] reg_sel;
    logic       ctrl_wr, tx_wr, stat_wr;
    logic       busy, tick;
    logic       done_set, done_clr, ovr_set, ovr_clr;
    logic       irq_en_q;
    logic       unused_bits;

    // Reset asserts asynchronously but releases two clocks later, in step with wb_clk_i.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign bus_acc = hit & ~ack_q;
    assign bus_wr  = bus_acc & wbs_we_i;
    assign bus_rd  = bus_acc & ~wbs_we_i;
    assign reg_sel = wbs_adr_i[3:2];
    assign ctrl_wr = bus_wr & (reg_sel == REG_CTRL);
    assign tx_wr   = bus_wr & (reg_sel == REG_TX) & wbs_sel_i[0];
    assign stat_wr = bus_wr & (reg_sel == REG_STAT) & wbs_sel_i[0];
    assign busy    = (state_q != ST_IDLE);
    assign tick    = (cnt_q == 8'd0);
    assign ovr_set = tx_wr & busy;
    assign ack_d   = bus_acc;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 4'd0;
            div_q   <= 8'h04;
            tx_q    <= 8'd0;
            rxsh_q  <= 8'd0;
            rx_q    <= 8'd0;
            sck_q   <= 1'b0;
            csn_q   <= 1'b1;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
            rxsh_q  <= rxsh_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            csn_q   <= csn_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        csn_d    = csn_q;
        tx_d     = tx_q;
        rxsh_d   = rxsh_q;
        rx_d     = rx_q;
        div_d    = div_q;
        hold_d   = hold_q;
        done_set = 1'b0;

        // Reload uses the DIV in force at the boundary, so a mid-transfer change
        // only affects half periods that start after it.
        if (busy) cnt_d = tick ? div_q : cnt_q - 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (!hold_q) csn_d = 1'b1;
                if (tx_wr) begin
                    state_d = ST_SETUP;
                    cnt_d   = div_q;
                    bit_d   = 4'd0;
                    tx_d    = wbs_dat_i[7:0];
                    csn_d   = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    sck_d   = 1'b1;
                    rxsh_d  = {rxsh_q[6:0], spi_miso_i};
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sck_q) begin
                        sck_d = 1'b0;
                        bit_d = bit_q + 4'd1;
                        if (bit_q != 4'd7) tx_d = {tx_q[6:0], 1'b0};
                    end else if (bit_q == 4'd8) begin
                        state_d = ST_TAIL;
                    end else begin
                        sck_d  = 1'b1;
                        rxsh_d = {rxsh_q[6:0], spi_miso_i};
                    end
                end
            end
            ST_TAIL: begin
                if (tick) begin
                    state_d  = ST_IDLE;
                    rx_d     = rxsh_q;
                    done_set = 1'b1;
                    tx_d     = 8'd0;
                    csn_d    = ~hold_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ctrl_wr && wbs_sel_i[0]) div_d  = wbs_dat_i[7:0];
        if (ctrl_wr && wbs_sel_i[1]) hold_d = wbs_dat_i[9];
    end

    // Status flags: a set on the same edge as a clear always wins.
    always_comb begin
        done_clr = 1'b0;
        ovr_clr  = 1'b0;
        rdata_d  = 32'd0;
        if (stat_wr) begin
            done_clr = wbs_dat_i[1];
            ovr_clr  = wbs_dat_i[2];
        end
        if (bus_rd) begin
            case (reg_sel)
                REG_CTRL: rdata_d = {22'd0, hold_q, irq_en_q, div_q};
                REG_RX: begin
                    rdata_d  = {24'd0, rx_q};
                    done_clr = 1'b1;
                end
                REG_STAT: rdata_d = {29'd0, ovr_q, done_q, busy};
                default:  rdata_d = 32'd0;
            endcase
        end
        done_d = done_set | (done_q & ~done_clr);
        ovr_d  = ovr_set | (ovr_q & ~ovr_clr);
    end

`ifdef SPI_IRQ_EN
    logic irq_en_d, irq_q, irq_d;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr && wbs_sel_i[1]) irq_en_d = wbs_dat_i[8];
        irq_d = done_d & irq_en_d;
    end

    assign irq_o = irq_q;
`else
    assign irq_en_q = 1'b0;
    assign irq_o    = 1'b0;
`endif

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = ack_q ? rdata_q : 32'd0;
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = tx_q[7];
    assign spi_csn_o  = csn_q;
    assign io_oeb_o   = 4'b1000;

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:10], wbs_dat_i[8]};

endmodule

// File: doc/mpw_wb_spi_master.md
MPW_WB_SPI_MASTER -- requirements
Module: mpw_wb_spi_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base of the 16-byte register window (bits [3:0] ignored).
REQ-002 SHALL have ports: wb_clk_i  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
REQ-005 SHALL have wbs_sel_i  in  4, wbs_adr_i  in  32, wbs_dat_i  in  32  Wishbone byte-select, address, write data.
REQ-006 SHALL have wbs_ack_o  out  1, wbs_dat_o  out  32  Wishbone acknowledge, read data.
REQ-007 SHALL have spi_sck_o, spi_mosi_o, spi_csn_o  out  1 each; spi_miso_i  in  1  SPI pad signals.
REQ-008 SHALL have io_oeb_o  out  4  pad output-enable-bar, bit order {miso,csn,mosi,sck}; irq_o  out  1  transfer-done interrupt.

Function
REQ-009 SHALL decode a hit when wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]); misses never ack.
REQ-010 SHALL assert wbs_ack_o exactly one cycle, the cycle after a hit; no back-to-back ack (a held strobe acks every second cycle).
REQ-011 SHALL drive wbs_dat_o with read data only during ack, else 32'h0; unmapped bits read 0.
REQ-012 Register 0x0 CTRL: [7:0] DIV (reset 8'h04), [8] IRQ_EN (reset 0), [9] CS_HOLD (reset 0); writes honour wbs_sel_i per byte.
REQ-013 Register 0x4 TXDATA: write with sel[0]=1 while idle launches an 8-bit transfer of dat_i[7:0]; write while busy is dropped and sets OVR; reads 0.
REQ-014 Register 0x8 RXDATA: [7:0] last received byte (reset 0); a read clears DONE.
REQ-015 Register 0xC STATUS: [0] BUSY (RO), [1] DONE, [2] OVR; writing 1 to bit 1 or 2 clears it.
REQ-016 SHALL use SPI mode 0: SCK idles low, MOSI MSB first, MISO sampled on SCK rising edge; half period H = DIV+1 clocks.
REQ-017 FSM states IDLE -> SETUP (csn low, MOSI=bit7, H cycles) -> SHIFT (8 x {SCK high H, SCK low H}, next bit on falling edge) -> TAIL (H cycles) -> IDLE.
REQ-018 BUSY SHALL read 1 from the edge registering the accepting write until TAIL completes; transfer lasts exactly 18*H cycles.
REQ-019 On TAIL->IDLE: RXDATA updated, DONE set, csn returns high unless CS_HOLD=1 (then stays low until CS_HOLD cleared while idle).
REQ-020 Simultaneous DONE-set and clear (W1C or RXDATA read) SHALL resolve set-wins; OVR likewise.
REQ-021 io_oeb_o SHALL be constant 4'b1000.
REQ-022 DIV change during a transfer SHALL take effect at the next half-period boundary only.

Reset
REQ-023 On wb_rst_ni low, immediately: wbs_ack_o=0, wbs_dat_o=0, spi_sck_o=0, spi_mosi_o=0, spi_csn_o=1, irq_o=0, FSM=IDLE, registers to reset values, including mid-transfer.
REQ-024 Deassertion SHALL be synchronised so the first active edge sees a clean reset release.

Configuration
REQ-025 Macro SPI_IRQ_EN defined: irq_o = DONE & IRQ_EN (registered level), IRQ_EN read/write.
REQ-026 SPI_IRQ_EN undefined: irq_o tied 0, CTRL[8] not stored and reads 0; all else identical.

Verification
REQ-027 Reset mid-transfer (cycle 10 of 90) -> csn=1, sck=0, BUSY=0, RXDATA=0 next read.
REQ-028 DIV=4, write TXDATA=8'hA5, MISO loopback to MOSI -> 8 SCK pulses width 5, transfer 90 cycles, RXDATA=8'hA5, DONE=1.
REQ-029 DIV=0, TXDATA write during busy -> OVR=1, shifted byte unchanged, W1C 4 clears OVR.
REQ-030 IRQ_EN=1, transfer done -> irq_o=1; read RXDATA -> irq_o=0 next cycle (SPI_IRQ_EN defined); always 0 when undefined.
REQ-031 CS_HOLD=1, two transfers 8'h01, 8'h02 -> csn low across both; clear CS_HOLD -> csn high.
REQ-032 Access at BASE_ADDR+0x10 -> no ack within 8 cycles; held strobe on CTRL -> ack pulses alternate cycles.
